// File: rtl/key_g_word_if.sv
// Request/result bundle of the AES-128 key-schedule G-function stage.
interface key_g_word_if;
  logic        enable;
  logic [31:0] inputVal;
  logic [3:0]  roundNum;
  logic [31:0] finalOutputVal;
  logic        done;

  modport master (output enable, inputVal, roundNum, input finalOutputVal, done);
  modport slave  (input enable, inputVal, roundNum, output finalOutputVal, done);
endinterface

// File: rtl/key_g_word.sv
// AES-128 key-expansion G function: RotWord -> SubWord -> Rcon XOR.
// One shared S-box is walked over the four bytes, one byte per cycle.
module key_g_word (
  input  logic         clk,
  input  logic         rst,
  key_g_word_if.slave  io_kg
);

  typedef enum logic [2:0] {
    S_IDLE, S_SUB0, S_SUB1, S_SUB2, S_SUB3, S_RCON, S_DONE, S_HOLD
  } state_t;

  // FIPS-197 forward S-box; entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant; out-of-range rounds yield zero rather than an error.
  function automatic logic [7:0] rcon_of(input logic [3:0] rn);
    case (rn)
      4'd1:    rcon_of = 8'h01;
      4'd2:    rcon_of = 8'h02;
      4'd3:    rcon_of = 8'h04;
      4'd4:    rcon_of = 8'h08;
      4'd5:    rcon_of = 8'h10;
      4'd6:    rcon_of = 8'h20;
      4'd7:    rcon_of = 8'h40;
      4'd8:    rcon_of = 8'h80;
      4'd9:    rcon_of = 8'h1b;
      4'd10:   rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

  state_t      r_state, w_next;
  logic [31:0] r_work;
  logic [7:0]  r_rcon;
  logic [31:0] r_out;
  logic        w_done;
  logic [7:0]  w_sbox_addr;
  logic [7:0]  w_sbox_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and the Moore done decode; HOLD blocks re-trigger on a held enable.
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (io_kg.enable) w_next = S_SUB0;
      S_SUB0: w_next = S_SUB1;
      S_SUB1: w_next = S_SUB2;
      S_SUB2: w_next = S_SUB3;
      S_SUB3: w_next = S_RCON;
      S_RCON: w_next = S_DONE;
      S_DONE: begin
        w_done = 1'b1;
        w_next = io_kg.enable ? S_HOLD : S_IDLE;
      end
      S_HOLD: if (!io_kg.enable) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // S-box address mux: most significant byte is substituted first.
  always_comb begin
    w_sbox_addr = 8'h00;
    case (r_state)
      S_SUB0:  w_sbox_addr = r_work[31:24];
      S_SUB1:  w_sbox_addr = r_work[23:16];
      S_SUB2:  w_sbox_addr = r_work[15:8];
      S_SUB3:  w_sbox_addr = r_work[7:0];
      default: w_sbox_addr = 8'h00;
    endcase
  end

  assign w_sbox_data = SBOX[w_sbox_addr];

  // Datapath: latch rotated word on start, substitute in place, fold in Rcon.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= 32'h0;
      r_rcon <= 8'h0;
      r_out  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: if (io_kg.enable) begin
          r_work <= {io_kg.inputVal[23:0], io_kg.inputVal[31:24]};
          r_rcon <= rcon_of(io_kg.roundNum);
        end
        S_SUB0: r_work[31:24] <= w_sbox_data;
        S_SUB1: r_work[23:16] <= w_sbox_data;
        S_SUB2: r_work[15:8]  <= w_sbox_data;
        S_SUB3: r_work[7:0]   <= w_sbox_data;
        S_RCON: r_out <= r_work ^ {r_rcon, 24'h0};
        default: ;
      endcase
    end
  end

  assign io_kg.finalOutputVal = r_out;
  assign io_kg.done           = w_done;

endmodule
